// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
// Shared definitions for the ALU issue slice: R-type opcode/func codes,
// instruction field bit positions, register-file depth and the FSM state
// encoding. Field extraction helpers keep the bit positions in one place.
package alu_issue_pkg;

  localparam int NUM_REGS = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] FN_SLL   = 6'b000000;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_WB   = 2'b10
  } state_e;

  function automatic logic [5:0] f_opcode(input logic [31:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] w);
    return w[RT_MSB:RT_LSB];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] w);
    return w[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [5:0] f_func(input logic [31:0] w);
    return w[FN_MSB:FN_LSB];
  endfunction

  // Only R-type SLL is executed; everything else is reported as illegal.
  function automatic logic f_is_sll(input logic [31:0] w);
    return (f_opcode(w) == OP_RTYPE) && (f_func(w) == FN_SLL);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if
// Bundles every non-clock/reset signal of alu_issue.
//   instr_valid/instr/instr_ready : instruction offer handshake
//   alu_instr/alu_gr1/alu_result  : connection to the external ALU
//   wr_en/wr_addr/wr_data         : host register preload
//   dbg_addr/dbg_data             : combinational register readback
//   done/illegal/wb_addr/wb_data  : completion report
// slave = issue unit view, master = host/ALU view.
interface alu_issue_if #(parameter int XLEN = 32);
  logic            instr_valid;
  logic [31:0]     instr;
  logic            instr_ready;
  logic [31:0]     alu_instr;
  logic [XLEN-1:0] alu_gr1;
  logic [XLEN-1:0] alu_result;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;
  logic            done;
  logic            illegal;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  modport slave (
    input  instr_valid, instr, alu_result, wr_en, wr_addr, wr_data, dbg_addr,
    output instr_ready, alu_instr, alu_gr1, dbg_data, done, illegal, wb_addr, wb_data
  );

  modport master (
    output instr_valid, instr, alu_result, wr_en, wr_addr, wr_data, dbg_addr,
    input  instr_ready, alu_instr, alu_gr1, dbg_data, done, illegal, wb_addr, wb_data
  );
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile
// 32 x XLEN register file, one write port, two combinational read ports.
//   clk, rst_n         : clock, asynchronous active-low reset (clears all regs)
//   i_we/i_waddr/i_wdata : write port (writes to reg 0 are dropped)
//   i_rt_addr/o_rt_data  : operand read port
//   i_dbg_addr/o_dbg_data: debug read port
module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_rt_addr,
  output logic [XLEN-1:0] o_rt_data,
  input  logic [4:0]      i_dbg_addr,
  output logic [XLEN-1:0] o_dbg_data
);

  // Reset-clear of every entry rules out a block RAM; this is flop storage.
  logic [XLEN-1:0] r_regs [NUM_REGS];

  // Entry 0 is cleared on reset and never written, so it always reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rt_data  = r_regs[i_rt_addr];
  assign o_dbg_data = r_regs[i_dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// alu_issue
// Issues MIPS R-type words to an external ALU one at a time
// (IDLE -> EXEC -> WB), writes SLL results back to the register file and
// reports completion. Any non-SLL word completes with illegal=1, no write.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_issue_if.slave (handshake, ALU link, preload, debug, report)
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);

  state_e          r_state;
  state_e          w_state_next;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_gr1;
  logic            r_done;
  logic            r_illegal;
  logic [4:0]      r_wb_addr;
  logic [XLEN-1:0] r_wb_data;

  logic            w_ready;
  logic            w_accept;
  logic            w_legal;
  logic            w_we;
  logic [4:0]      w_waddr;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_rt_data;

  // A host write in IDLE takes the cycle; the offer is accepted afterwards.
  assign w_ready  = (r_state == S_IDLE) && !bus.wr_en;
  assign w_accept = bus.instr_valid && w_ready;
  assign w_legal  = f_is_sll(r_instr);

  // Host writes (IDLE) and result writes (EXEC->WB) never share a cycle.
  assign w_we    = ((r_state == S_IDLE) && bus.wr_en) ||
                   ((r_state == S_EXEC) && w_legal);
  assign w_waddr = (r_state == S_IDLE) ? bus.wr_addr : f_rd(r_instr);
  assign w_wdata = (r_state == S_IDLE) ? bus.wr_data : bus.alu_result;

  alu_regfile #(.XLEN(XLEN)) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_we),
    .i_waddr    (w_waddr),
    .i_wdata    (w_wdata),
    .i_rt_addr  (f_rt(bus.instr)),
    .o_rt_data  (w_rt_data),
    .i_dbg_addr (bus.dbg_addr),
    .o_dbg_data (bus.dbg_data)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_WB;
      S_WB:    w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_instr   <= '0;
      r_gr1     <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_instr <= bus.instr;
        r_gr1   <= w_rt_data;
      end
      // done/illegal are high exactly while in WB.
      r_done    <= (r_state == S_EXEC);
      r_illegal <= (r_state == S_EXEC) && !w_legal;
      if (r_state == S_EXEC) begin
        r_wb_addr <= f_rd(r_instr);
        r_wb_data <= bus.alu_result;
      end
    end
  end

  assign bus.instr_ready = w_ready;
  assign bus.alu_instr   = (r_state == S_EXEC) ? r_instr : '0;
  assign bus.alu_gr1     = (r_state == S_EXEC) ? r_gr1   : '0;
  assign bus.done        = r_done;
  assign bus.illegal     = r_illegal;
  assign bus.wb_addr     = r_wb_addr;
  assign bus.wb_data     = r_wb_data;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue
// Directed bench for alu_issue with a behavioural SLL ALU attached.
module tb_alu_issue;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_if #(.XLEN(32)) bus ();

  alu_issue #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External ALU: shift gr1 left by the shamt field.
  assign bus.alu_result = bus.alu_gr1 << bus.alu_instr[10:6];

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] enc_sll(input logic [4:0] rd, input logic [4:0] rt,
                                          input logic [4:0] sh);
    return {6'd0, 5'd0, rt, rd, sh, 6'd0};
  endfunction

  task automatic host_write(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
    bus.dbg_addr = a;
    @(negedge clk);
    d = bus.dbg_data;
    @(posedge clk); #1;
  endtask

  // Offers w, waits (bounded) for accept and done, returns what was seen.
  task automatic run_instr(input logic [31:0] w, output logic accepted, output int lat,
                           output logic ill, output logic [4:0] wa, output logic [31:0] wd,
                           output logic [31:0] ex_instr, output logic [31:0] ex_gr1,
                           output logic done_after);
    accepted = 1'b0; lat = 99; ill = 1'b0; wa = '0; wd = '0;
    ex_instr = '0; ex_gr1 = '0; done_after = 1'b1;
    bus.instr = w; bus.instr_valid = 1'b1;
    for (int k = 0; k < 10 && !accepted; k++) begin
      #1;
      if (bus.instr_ready) accepted = 1'b1;
      @(posedge clk); #1;
    end
    bus.instr_valid = 1'b0;
    if (!accepted) begin
      $display("txn instr=%08h not accepted", w);
      return;
    end
    ex_instr = bus.alu_instr;
    ex_gr1   = bus.alu_gr1;
    for (int k = 1; k <= 6; k++) begin
      if (bus.done) begin
        lat = k; ill = bus.illegal; wa = bus.wb_addr; wd = bus.wb_data;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    done_after = bus.done;
    $display("txn instr=%08h lat=%0d illegal=%0b wb_addr=%0d wb_data=%08h",
             w, lat, ill, wa, wd);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0; bus.instr = '0; bus.wr_en = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.dbg_addr = 5'd7;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
    checks++; if (bus.alu_instr !== 32'h0) begin failures++; $display("FAIL reset_alu_instr got=%08h exp=0", bus.alu_instr); end
    checks++; if (bus.wb_data !== 32'h0 || bus.wb_addr !== 5'd0) begin failures++; $display("FAIL reset_wb got=%0d/%08h exp=0/0", bus.wb_addr, bus.wb_data); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", bus.instr_ready); end
    @(posedge clk); #1;
    read_reg(5'd7, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_r7 got=%08h exp=0", d); end
  endtask

  task automatic test_sll_basic();
    logic acc, ill, da; int lat; logic [4:0] wa; logic [31:0] wd, ei, eg, d;
    host_write(5'd1, 32'h0000_0003);
    checks++; if (bus.alu_instr !== 32'h0) begin failures++; $display("FAIL idle_alu_instr got=%08h exp=0", bus.alu_instr); end
    run_instr(32'h0001_1080, acc, lat, ill, wa, wd, ei, eg, da);
    checks++; if (acc !== 1'b1 || lat != 2) begin failures++; $display("FAIL sll_latency got=acc%0b/%0d exp=acc1/2", acc, lat); end
    checks++; if (ei !== 32'h0001_1080 || eg !== 32'h3) begin failures++; $display("FAIL sll_exec_drive got=%08h/%08h exp=00011080/00000003", ei, eg); end
    checks++; if (wa !== 5'd2 || wd !== 32'hC || ill !== 1'b0) begin failures++; $display("FAIL sll_wb got=%0d/%08h/ill%0b exp=2/0000000c/ill0", wa, wd, ill); end
    checks++; if (da !== 1'b0) begin failures++; $display("FAIL sll_done_one_cycle got=%0b exp=0", da); end
    read_reg(5'd2, d);
    checks++; if (d !== 32'hC) begin failures++; $display("FAIL sll_dbg_r2 got=%08h exp=0000000c", d); end
  endtask

  task automatic test_back_to_back();
    logic acc, ill, da; int lat; logic [4:0] wa; logic [31:0] wd, ei, eg;
    host_write(5'd1, 32'h8000_0001);
    run_instr(enc_sll(5'd3, 5'd1, 5'd31), acc, lat, ill, wa, wd, ei, eg, da);
    checks++; if (wa !== 5'd3 || wd !== 32'h8000_0000 || lat != 2) begin failures++; $display("FAIL b2b_first got=%0d/%08h/lat%0d exp=3/80000000/lat2", wa, wd, lat); end
    run_instr(enc_sll(5'd4, 5'd3, 5'd1), acc, lat, ill, wa, wd, ei, eg, da);
    checks++; if (eg !== 32'h8000_0000) begin failures++; $display("FAIL b2b_forward_gr1 got=%08h exp=80000000", eg); end
    checks++; if (wa !== 5'd4 || wd !== 32'h0 || lat != 2) begin failures++; $display("FAIL b2b_second got=%0d/%08h/lat%0d exp=4/00000000/lat2", wa, wd, lat); end
  endtask

  task automatic test_illegal();
    logic acc, ill, da; int lat; logic [4:0] wa; logic [31:0] wd, ei, eg, d;
    logic [31:0] exp_regs [5];
    exp_regs[0] = 32'h0; exp_regs[1] = 32'h8000_0001; exp_regs[2] = 32'hC;
    exp_regs[3] = 32'h8000_0000; exp_regs[4] = 32'h0;
    run_instr(32'h2001_0005, acc, lat, ill, wa, wd, ei, eg, da);
    checks++; if (lat != 2 || ill !== 1'b1 || wa !== 5'd0) begin failures++; $display("FAIL illegal_opcode got=lat%0d/ill%0b/%0d exp=lat2/ill1/0", lat, ill, wa); end
    checks++; if (wd !== 32'h8000_0001) begin failures++; $display("FAIL illegal_wb_data got=%08h exp=80000001", wd); end
    // R-type with func=2 aimed at r2: must not write.
    run_instr(32'h0001_1002, acc, lat, ill, wa, wd, ei, eg, da);
    checks++; if (lat != 2 || ill !== 1'b1 || wa !== 5'd2) begin failures++; $display("FAIL illegal_func got=lat%0d/ill%0b/%0d exp=lat2/ill1/2", lat, ill, wa); end
    for (int r = 0; r < 5; r++) begin
      read_reg(5'(r), d);
      checks++; if (d !== exp_regs[r]) begin failures++; $display("FAIL illegal_reg_r%0d got=%08h exp=%08h", r, d, exp_regs[r]); end
    end
  endtask

  task automatic test_wr_block();
    logic [31:0] d;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd6; bus.wr_data = 32'h55;
    bus.instr = enc_sll(5'd7, 5'd6, 5'd4); bus.instr_valid = 1'b1;
    #1;
    checks++; if (bus.instr_ready !== 1'b0) begin failures++; $display("FAIL wrblk_ready_low got=%0b exp=0", bus.instr_ready); end
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    #1;
    checks++; if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL wrblk_ready_next got=%0b exp=1", bus.instr_ready); end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    checks++; if (bus.alu_gr1 !== 32'h55 || bus.alu_instr !== enc_sll(5'd7, 5'd6, 5'd4)) begin failures++; $display("FAIL wrblk_exec got=%08h/%08h exp=00000055/%08h", bus.alu_gr1, bus.alu_instr, enc_sll(5'd7, 5'd6, 5'd4)); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b1 || bus.wb_addr !== 5'd7 || bus.wb_data !== 32'h550) begin failures++; $display("FAIL wrblk_wb got=%0b/%0d/%08h exp=1/7/00000550", bus.done, bus.wb_addr, bus.wb_data); end
    $display("txn instr=%08h wb_addr=%0d wb_data=%08h", enc_sll(5'd7, 5'd6, 5'd4), bus.wb_addr, bus.wb_data);
    @(posedge clk); #1;
    read_reg(5'd6, d);
    checks++; if (d !== 32'h55) begin failures++; $display("FAIL wrblk_r6 got=%08h exp=00000055", d); end
  endtask

  task automatic test_reset_mid_exec();
    logic seen_done; logic [31:0] d;
    bus.dbg_addr = 5'd1;
    bus.instr = enc_sll(5'd5, 5'd1, 5'd1); bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    checks++; if (bus.alu_instr !== enc_sll(5'd5, 5'd1, 5'd1)) begin failures++; $display("FAIL rstmid_in_exec got=%08h exp=%08h", bus.alu_instr, enc_sll(5'd5, 5'd1, 5'd1)); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.alu_instr !== 32'h0 || bus.dbg_data !== 32'h0) begin failures++; $display("FAIL rstmid_async got=%08h/%08h exp=0/0", bus.alu_instr, bus.dbg_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%0b exp=1", bus.instr_ready); end
    seen_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      seen_done = seen_done | bus.done;
    end
    checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL rstmid_no_done got=%0b exp=0", seen_done); end
    read_reg(5'd5, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rstmid_r5 got=%08h exp=0", d); end
    $display("txn instr=%08h abandoned by reset", enc_sll(5'd5, 5'd1, 5'd1));
  endtask

  task automatic test_r0_dest();
    logic acc, ill, da; int lat; logic [4:0] wa; logic [31:0] wd, ei, eg, d;
    host_write(5'd1, 32'h1);
    run_instr(enc_sll(5'd0, 5'd1, 5'd4), acc, lat, ill, wa, wd, ei, eg, da);
    checks++; if (lat != 2 || ill !== 1'b0 || wa !== 5'd0 || wd !== 32'h10) begin failures++; $display("FAIL r0dest_wb got=lat%0d/ill%0b/%0d/%08h exp=lat2/ill0/0/00000010", lat, ill, wa, wd); end
    read_reg(5'd0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL r0dest_r0 got=%08h exp=0", d); end
    run_instr(32'h0, acc, lat, ill, wa, wd, ei, eg, da);
    checks++; if (lat != 2 || ill !== 1'b0 || wa !== 5'd0) begin failures++; $display("FAIL nop got=lat%0d/ill%0b/%0d exp=lat2/ill0/0", lat, ill, wa); end
    read_reg(5'd1, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL nop_r1 got=%08h exp=00000001", d); end
  endtask

  initial begin
    test_reset();
    test_sll_basic();
    test_back_to_back();
    test_illegal();
    test_wr_block();
    test_reset_mid_exec();
    test_r0_dest();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: instr_valid  input  1  instruction word offered.
REQ-005 SHALL have port: instr  input  32  MIPS R-type word: opcode[31:26], rt[20:16], rd[15:11], shamt[10:6], func[5:0].
REQ-006 SHALL have port: instr_ready  output  1  issue unit can accept an instruction this cycle.
REQ-007 SHALL have port: alu_instr  output  32  instruction word driven to the ALU's i_datain.
REQ-008 SHALL have port: alu_gr1  output  32  operand driven to the ALU's gr1.
REQ-009 SHALL have port: alu_result  input  32  ALU combinational result c.
REQ-010 SHALL have port: wr_en / wr_addr / wr_data  input  1/5/32  host register preload.
REQ-011 SHALL have port: dbg_addr / dbg_data  input 5 / output 32  combinational register readback.
REQ-012 SHALL have port: done / illegal / wb_addr / wb_data  output  1/1/5/32  completion report.

Function
REQ-013 SHALL hold a 32 x 32 register file; reg 0 reads 0 and ignores all writes.
REQ-014 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; no other transitions except reset.
REQ-015 SHALL assert instr_ready only in IDLE and only when wr_en=0.
REQ-016 SHALL accept on instr_valid && instr_ready: latch instr, latch reg[rt] (pre-edge value), go EXEC.
REQ-017 SHALL drive alu_instr/alu_gr1 from the latched values during EXEC and hold them stable; 0 in IDLE and WB.
REQ-018 SHALL, at the EXEC->WB edge, write alu_result to reg[rd] if opcode=0 and func=0 (SLL); otherwise no write.
REQ-019 SHALL in WB assert done for exactly one cycle with wb_addr=rd, wb_data=captured alu_result, illegal=1 iff opcode!=0 or func!=0.
REQ-020 SHALL keep done/illegal at 0 outside WB; wb_addr/wb_data hold last value.
REQ-021 SHALL give latency accept-edge to done = 2 cycles; throughput one instruction per 3 cycles.
REQ-022 SHALL make a write visible to the next accepted instruction (no hazard; write precedes next accept).
REQ-023 SHALL perform host writes only in IDLE; wr_en outside IDLE is ignored; wr_en in IDLE blocks accept that cycle.
REQ-024 SHALL return reg[dbg_addr] combinationally, reflecting writes from the following cycle on.
REQ-025 SHALL treat instr=0 (sll r0,r0,0) as a legal NOP: done=1, wb_addr=0, no state change.

Reset
REQ-026 SHALL on rst_n=0 immediately enter IDLE, clear all 32 registers, latched instr/operand, done, illegal, wb_addr, wb_data to 0.
REQ-027 SHALL abandon an in-flight instruction on reset mid-EXEC/WB with no register write and no done pulse.
REQ-028 SHALL assert instr_ready=1 in the first cycle after rst_n deasserts.

Structure
REQ-029 SHALL place opcode/func constants (OP_RTYPE=6'b000000, FN_SLL=6'b000000), field bit positions and FSM state encoding in a shared package.
REQ-030 SHALL contain one sub-module, alu_regfile (32x32, one write port, two combinational read ports: rt, dbg).
REQ-031 SHALL not instantiate the ALU; the ALU is connected externally at the top level.

Verification
REQ-032 SHALL cover: preload r1=0x0000_0003; issue 0x0001_1080 (sll r2,r1,2) -> done 2 cycles after accept, wb_addr=2, wb_data=0x0000_000C, dbg r2=0x0000_000C.
REQ-033 SHALL cover: r1=0x8000_0001, sll r3,r1,31 -> wb_data=0x8000_0000; then sll r4,r3,1 back-to-back -> wb_data=0.
REQ-034 SHALL cover: issue 0x2001_0005 (opcode 8) -> done=1, illegal=1, no register changes.
REQ-035 SHALL cover: wr_en=1 with instr_valid=1 in IDLE -> instr_ready=0, write performed, instruction accepted next cycle.
REQ-036 SHALL cover: rst_n low during EXEC of sll r5,r1,1 -> no done, r5=0, instr_ready=1 after release.
REQ-037 SHALL cover: sll r0,r1,4 with r1=1 -> done=1, wb_addr=0, dbg r0=0.
